// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multicycle fetch/decode/execute/memory/writeback control FSM
module cpu_ctrl_fsm #(
    parameter int DWIDTH = 32,
    parameter int OPW    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] instr,
    input  logic              imem_ready,
    input  logic              dmem_ready,
    input  logic              alu_done,
    output logic              imem_req,
    output logic              ir_we,
    output logic              pc_we,
    output logic              rf_re,
    output logic              alu_start,
    output logic [OPW-1:0]    alu_op,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic              rf_we,
    output logic              wb_sel,
    output logic              illegal,
    output logic              busy
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] DECODE = 3'd2;
    localparam logic [2:0] EXEC   = 3'd3;
    localparam logic [2:0] EXWAIT = 3'd4;
    localparam logic [2:0] MEM    = 3'd5;
    localparam logic [2:0] WB     = 3'd6;
    localparam logic [2:0] HALT   = 3'd7;

    localparam logic [OPW-1:0] OP_LW  = OPW'(0);
    localparam logic [OPW-1:0] OP_SW  = OPW'(1);
    localparam logic [OPW-1:0] OP_RSV = OPW'(2);
    localparam logic [OPW-1:0] OP_MUL = OPW'(5);
    localparam logic [OPW-1:0] OP_DIV = OPW'(6);
    localparam logic [OPW-1:0] OP_CMP = OPW'(11);
    localparam logic [OPW-1:0] OP_NOT = OPW'(12);

    logic [2:0]     state_q, state_d;
    logic [OPW-1:0] ir_op_q, alu_op_q;
    logic           illegal_q;
    logic           legal;
    logic           unused_instr_bits;

    // Only the opcode field steers control; operand fields belong to the datapath.
    assign unused_instr_bits = ^instr[DWIDTH-OPW-1:0];
    assign legal = (ir_op_q <= OP_NOT) && (ir_op_q != OP_RSV);

    // Next-state selection; alu_done/imem_ready/dmem_ready only matter in their own states.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   state_d = imem_ready ? DECODE : FETCH;
            DECODE:  state_d = legal ? EXEC : HALT;
            EXEC:    state_d = (alu_op_q == OP_MUL || alu_op_q == OP_DIV) ? EXWAIT :
                               (alu_op_q == OP_LW || alu_op_q == OP_SW)   ? MEM    :
                               (alu_op_q == OP_CMP)                       ? FETCH  : WB;
            EXWAIT:  state_d = alu_done ? WB : EXWAIT;
            MEM:     state_d = dmem_ready ? ((alu_op_q == OP_LW) ? WB : FETCH) : MEM;
            WB:      state_d = FETCH;
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    // State, fetched opcode, ALU opcode held from DECODE, and sticky illegal flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ir_op_q   <= '0;
            alu_op_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == FETCH && imem_ready) ir_op_q <= instr[DWIDTH-1 -: OPW];
            if (state_q == DECODE) alu_op_q <= ir_op_q;
            if (state_q == DECODE && !legal) illegal_q <= 1'b1;
        end
    end

    // Moore enables; only the IR/PC write strobes look at imem_ready directly.
    always_comb begin
        imem_req  = state_q == FETCH;
        ir_we     = state_q == FETCH && imem_ready;
        pc_we     = state_q == FETCH && imem_ready;
        rf_re     = state_q == DECODE;
        alu_start = state_q == EXEC;
        dmem_req  = state_q == MEM;
        dmem_we   = state_q == MEM && alu_op_q == OP_SW;
        rf_we     = state_q == WB;
        wb_sel    = state_q == WB && alu_op_q == OP_LW;
        busy      = state_q != IDLE && state_q != HALT;
        illegal   = illegal_q;
        alu_op    = alu_op_q;
    end
endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb_cpu_ctrl_fsm: scoreboard bench replaying per-cycle stimulus against expected enables
module tb_cpu_ctrl_fsm;
    logic        clk = 0;
    logic        rst, imem_ready, dmem_ready, alu_done;
    logic [31:0] instr;
    logic        imem_req, ir_we, pc_we, rf_re, alu_start, dmem_req, dmem_we, rf_we, wb_sel, illegal, busy;
    logic [4:0]  alu_op;
    logic [15:0] obs;

    localparam logic [15:0] IMR = 16'h8000, IRW = 16'h4000, PCW = 16'h2000, RFR = 16'h1000;
    localparam logic [15:0] AST = 16'h0800, DRQ = 16'h0400, DWE = 16'h0200, RFW = 16'h0100;
    localparam logic [15:0] WBS = 16'h0080, ILL = 16'h0040, BSY = 16'h0020;
    localparam logic [15:0] FTC = IMR | IRW | PCW | BSY;

    typedef struct {
        logic        r;
        logic [4:0]  op;
        logic        ir, dr, ad;
        logic [15:0] e;
    } ent_t;

    ent_t sb[$];
    int   passed = 0, total = 0;

    cpu_ctrl_fsm #(.DWIDTH(32), .OPW(5)) dut (
        .clk(clk), .rst(rst), .instr(instr), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .alu_done(alu_done), .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we), .rf_re(rf_re),
        .alu_start(alu_start), .alu_op(alu_op), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .rf_we(rf_we), .wb_sel(wb_sel), .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    assign obs = {imem_req, ir_we, pc_we, rf_re, alu_start, dmem_req, dmem_we, rf_we,
                  wb_sel, illegal, busy, alu_op};

    task automatic push(input logic r, input logic [4:0] op, input logic ir, input logic dr,
                        input logic ad, input logic [15:0] e);
        ent_t x;
        x.r = r; x.op = op; x.ir = ir; x.dr = dr; x.ad = ad; x.e = e;
        sb.push_back(x);
    endtask

    task automatic apply(input ent_t x);
        rst        = x.r;
        instr      = {x.op, 27'($urandom)};
        imem_ready = x.ir;
        dmem_ready = x.dr;
        alu_done   = x.ad;
    endtask

    task automatic test_reset;
        push(1, 5'd0, 1, 1, 1, 16'h0);
        push(1, 5'd0, 0, 0, 0, 16'h0);
        while (sb.size() > 0) begin
            ent_t x;
            x = sb.pop_front();
            apply(x);
            @(negedge clk);
            total++;
            if (obs !== x.e) $display("FAIL reset: outputs %h expected %h", obs, x.e);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_add;
        push(0, 5'd3, 1, 1, 0, 16'h0);
        push(0, 5'd3, 1, 1, 0, FTC);
        push(0, 5'd3, 1, 1, 0, RFR | BSY);
        push(0, 5'd3, 1, 1, 0, AST | BSY | 16'd3);
        push(0, 5'd3, 1, 1, 0, RFW | BSY | 16'd3);
        while (sb.size() > 0) begin
            ent_t x;
            x = sb.pop_front();
            apply(x);
            @(negedge clk);
            total++;
            if (obs !== x.e) $display("FAIL add: outputs %h expected %h", obs, x.e);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lw;
        push(0, 5'd0, 0, 0, 0, IMR | BSY | 16'd3);
        push(0, 5'd0, 1, 0, 0, FTC | 16'd3);
        push(0, 5'd0, 1, 0, 0, RFR | BSY | 16'd3);
        push(0, 5'd0, 1, 0, 0, AST | BSY);
        for (int i = 0; i < 3; i++) push(0, 5'd0, 1, 0, 0, DRQ | BSY);
        push(0, 5'd0, 1, 1, 0, DRQ | BSY);
        push(0, 5'd0, 1, 1, 0, RFW | WBS | BSY);
        while (sb.size() > 0) begin
            ent_t x;
            x = sb.pop_front();
            apply(x);
            @(negedge clk);
            total++;
            if (obs !== x.e) $display("FAIL lw: outputs %h expected %h", obs, x.e);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw_cmp;
        push(0, 5'd1, 1, 1, 0, FTC);
        push(0, 5'd1, 1, 1, 0, RFR | BSY);
        push(0, 5'd1, 1, 1, 0, AST | BSY | 16'd1);
        push(0, 5'd1, 1, 1, 0, DRQ | DWE | BSY | 16'd1);
        push(0, 5'd11, 1, 1, 0, FTC | 16'd1);
        push(0, 5'd11, 1, 1, 0, RFR | BSY | 16'd1);
        push(0, 5'd11, 1, 1, 0, AST | BSY | 16'd11);
        while (sb.size() > 0) begin
            ent_t x;
            x = sb.pop_front();
            apply(x);
            @(negedge clk);
            total++;
            if (obs !== x.e) $display("FAIL sw_cmp: outputs %h expected %h", obs, x.e);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_div;
        push(0, 5'd6, 0, 0, 1, IMR | BSY | 16'd11);
        push(0, 5'd6, 1, 0, 1, FTC | 16'd11);
        push(0, 5'd6, 1, 0, 1, RFR | BSY | 16'd11);
        push(0, 5'd6, 1, 0, 1, AST | BSY | 16'd6);
        for (int i = 0; i < 4; i++) push(0, 5'd6, 1, 1, 0, BSY | 16'd6);
        push(0, 5'd6, 1, 1, 1, BSY | 16'd6);
        push(0, 5'd6, 1, 1, 0, RFW | BSY | 16'd6);
        while (sb.size() > 0) begin
            ent_t x;
            x = sb.pop_front();
            apply(x);
            @(negedge clk);
            total++;
            if (obs !== x.e) $display("FAIL div: outputs %h expected %h", obs, x.e);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rst_mid_sw;
        push(0, 5'd1, 1, 0, 0, FTC | 16'd6);
        push(0, 5'd1, 1, 0, 0, RFR | BSY | 16'd6);
        push(0, 5'd1, 1, 0, 0, AST | BSY | 16'd1);
        push(0, 5'd1, 1, 0, 0, DRQ | DWE | BSY | 16'd1);
        push(1, 5'd1, 1, 0, 0, DRQ | DWE | BSY | 16'd1);
        push(0, 5'd1, 1, 1, 0, 16'h0);
        while (sb.size() > 0) begin
            ent_t x;
            x = sb.pop_front();
            apply(x);
            @(negedge clk);
            total++;
            if (obs !== x.e) $display("FAIL rst_mid_sw: outputs %h expected %h", obs, x.e);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal;
        push(0, 5'd13, 1, 1, 0, FTC);
        push(0, 5'd13, 1, 1, 0, RFR | BSY);
        for (int i = 0; i < 4; i++) push(0, 5'd3, 1, 1, 1, ILL | 16'd13);
        push(1, 5'd3, 1, 1, 0, ILL | 16'd13);
        push(0, 5'd3, 1, 1, 0, 16'h0);
        push(0, 5'd3, 1, 1, 0, FTC);
        push(0, 5'd3, 1, 1, 0, RFR | BSY);
        while (sb.size() > 0) begin
            ent_t x;
            x = sb.pop_front();
            apply(x);
            @(negedge clk);
            total++;
            if (obs !== x.e) $display("FAIL illegal: outputs %h expected %h", obs, x.e);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1; instr = '0; imem_ready = 0; dmem_ready = 0; alu_done = 0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_add();
        test_lw();
        test_sw_cmp();
        test_div();
        test_rst_mid_sw();
        test_illegal();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
